// File: rtl/accel_mem_sequencer_pkg.sv
// rtl/accel_mem_sequencer_pkg.sv - shared types and helpers for the accelerator memory sequencer
//
// Purpose: command opcodes, sequencer FSM states, control-field width helper.
// Ports:   none (package).
package accel_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_READ   = 2'd1,
    OP_RUN    = 2'd2,
    OP_FINISH = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ_ISSUE,
    READ_DRAIN,
    RUN_START,
    RUN_WAIT,
    FINISH,
    DONE
  } state_e;

  // Width of the accelerator mem_ctrl_in word: namespace plus one
  // {pe_idx, valid} field per lane.
  function automatic int ctrl_w(input int log_mem_ns, input int log_pe_lanes,
                                input int num_lanes);
    return log_mem_ns + (log_pe_lanes + 1) * num_lanes;
  endfunction

endpackage

// File: rtl/accel_mem_sequencer_if.sv
// rtl/accel_mem_sequencer_if.sv - host-side and accelerator-side bundle of the memory sequencer
//
// Purpose: groups the command, load stream, read stream, accelerator memory
//          port and status signals.
// Modports:
//   slave  - the sequencer (consumes commands/load beats, drives accelerator)
//   master - the host/DMA wrapper plus accelerator model
// Signals: cmd_valid/ready/op/ns/len, in_valid/ready/data, out_valid/ready/data,
//          acc_start, acc_eoc, acc_mem_ctrl, acc_rd_wrt, acc_data_in,
//          acc_data_out, acc_eol, busy, done, err.
interface accel_mem_sequencer_if
  import accel_seq_pkg::*;
#(
  parameter int LOG_MEM_NS   = 2,
  parameter int NUM_LANES    = 16,
  parameter int LOG_PE_LANES = 2,
  parameter int DATA_LEN     = 16,
  parameter int LEN_W        = 16
);
  localparam int DW = DATA_LEN * NUM_LANES;
  localparam int CW = ctrl_w(LOG_MEM_NS, LOG_PE_LANES, NUM_LANES);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [LOG_MEM_NS-1:0] cmd_ns;
  logic [LEN_W-1:0]      cmd_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  acc_start;
  logic                  acc_eoc;
  logic [CW-1:0]         acc_mem_ctrl;
  logic                  acc_rd_wrt;
  logic [DW-1:0]         acc_data_in;
  logic [DW-1:0]         acc_data_out;
  logic                  acc_eol;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ns, cmd_len, in_valid, in_data, out_ready,
           acc_data_out, acc_eol,
    output cmd_ready, in_ready, out_valid, out_data, acc_start, acc_eoc,
           acc_mem_ctrl, acc_rd_wrt, acc_data_in, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ns, cmd_len, in_valid, in_data, out_ready,
           acc_data_out, acc_eol,
    input  cmd_ready, in_ready, out_valid, out_data, acc_start, acc_eoc,
           acc_mem_ctrl, acc_rd_wrt, acc_data_in, busy, done, err
  );

endinterface

// File: rtl/accel_mem_sequencer_seq_out_fifo.sv
// rtl/accel_mem_sequencer_seq_out_fifo.sv - synchronous read-return FIFO
//
// Purpose: holds captured read beats until the host consumes them.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   i_push       - write i_push_data (ignored when full)
//   i_pop        - drop the head entry (ignored when empty)
//   o_head       - head entry (valid when !o_empty)
//   o_empty      - no entries
//   o_count      - number of entries, 0..DEPTH
module seq_out_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_push_data,
  input  logic                     i_pop,
  output logic [DW-1:0]            o_head,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/accel_mem_sequencer.sv
// rtl/accel_mem_sequencer.sv - command sequencer for the accelerator memory port
//
// Purpose: executes LOAD / READ / RUN / FINISH commands against the
//          accelerator memory interface, cycling the PE-lane select per beat
//          and capturing read returns into a credit-protected FIFO.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high
//   bus    - accel_mem_sequencer_if.slave (command, load/read streams,
//            accelerator memory port, busy/done/err)
// Build option: SEQ_RUN_TIMEOUT_EN enables the RUN watchdog (TIMEOUT_CYCLES);
//               without it RUN waits indefinitely and err is tied 0.
module accel_mem_sequencer
  import accel_seq_pkg::*;
#(
  parameter int LOG_MEM_NS   = 2,
  parameter int NUM_LANES    = 16,
  parameter int LOG_PE_LANES = 2,
  parameter int DATA_LEN     = 16,
  parameter int RD_LATENCY   = 5,
  parameter int LEN_W        = 16,
  parameter int OFIFO_DEPTH  = 8
`ifdef SEQ_RUN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  accel_mem_sequencer_if.slave bus
);
  localparam int DW    = DATA_LEN * NUM_LANES;
  localparam int CW    = ctrl_w(LOG_MEM_NS, LOG_PE_LANES, NUM_LANES);
  localparam int PE_W  = LOG_PE_LANES;
  localparam int CRD_W = $clog2(OFIFO_DEPTH + 1);
  localparam int FC_W  = $clog2(OFIFO_DEPTH) + 1;
`ifdef SEQ_RUN_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
`endif

  state_e                r_state;
  logic [LOG_MEM_NS-1:0] r_ns;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_beat_cnt;
  logic [PE_W-1:0]       r_pe_idx;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [CRD_W-1:0]      r_credits;
  logic [RD_LATENCY-1:0] r_rd_pipe;

  logic                  r_acc_start;
  logic                  r_acc_eoc;
  logic                  r_acc_valid;
  logic                  r_acc_rd_wrt;
  logic [LOG_MEM_NS-1:0] r_acc_ns;
  logic [PE_W-1:0]       r_acc_pe;
  logic [DW-1:0]         r_acc_data_in;
  logic                  r_done;

  logic                  w_in_fire;
  logic                  w_rd_issue;
  logic                  w_last_beat;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [FC_W-1:0]       w_fifo_count;
  logic [DW-1:0]         w_fifo_head;
  logic [CW-1:0]         w_ctrl;

  assign w_in_fire   = (r_state == LOAD) && bus.in_valid;
  assign w_rd_issue  = (r_state == READ_ISSUE) && (r_credits != '0);
  assign w_last_beat = (r_beat_cnt == (r_len - LEN_W'(1)));
  assign w_pop       = !w_fifo_empty && bus.out_ready;
  // The full check is a backstop; credits already keep the FIFO from overflowing.
  assign w_push      = r_rd_pipe[RD_LATENCY-1] && (w_fifo_count != FC_W'(OFIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ns          <= '0;
      r_len         <= '0;
      r_beat_cnt    <= '0;
      r_pe_idx      <= '0;
      r_wait_cnt    <= '0;
      r_acc_start   <= 1'b0;
      r_acc_eoc     <= 1'b0;
      r_acc_valid   <= 1'b0;
      r_acc_rd_wrt  <= 1'b0;
      r_acc_ns      <= '0;
      r_acc_pe      <= '0;
      r_acc_data_in <= '0;
      r_done        <= 1'b0;
    end else begin
      // Strobes default low; a state sets them only for the cycle it needs.
      r_acc_start  <= 1'b0;
      r_acc_eoc    <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_acc_rd_wrt <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_ns       <= bus.cmd_ns;
              r_len      <= bus.cmd_len;
              r_beat_cnt <= '0;
              r_pe_idx   <= '0;
              case (op_e'(bus.cmd_op))
                OP_LOAD:   r_state <= LOAD;
                OP_READ:   r_state <= READ_ISSUE;
                OP_RUN: begin
                  r_state     <= RUN_START;
                  r_acc_start <= 1'b1;
                end
                OP_FINISH: begin
                  r_state   <= FINISH;
                  r_acc_eoc <= 1'b1;
                end
                default:   r_state <= IDLE;
              endcase
            end
          end
        end
        LOAD: begin
          if (w_in_fire) begin
            r_acc_valid   <= 1'b1;
            r_acc_ns      <= r_ns;
            r_acc_pe      <= r_pe_idx;
            r_acc_data_in <= bus.in_data;
            r_pe_idx      <= r_pe_idx + PE_W'(1);
            r_beat_cnt    <= r_beat_cnt + LEN_W'(1);
            if (w_last_beat) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        READ_ISSUE: begin
          if (w_rd_issue) begin
            r_acc_valid  <= 1'b1;
            r_acc_rd_wrt <= 1'b1;
            r_acc_ns     <= r_ns;
            r_acc_pe     <= r_pe_idx;
            r_pe_idx     <= r_pe_idx + PE_W'(1);
            r_beat_cnt   <= r_beat_cnt + LEN_W'(1);
            if (w_last_beat) r_state <= READ_DRAIN;
          end
        end
        READ_DRAIN: begin
          // The final issue is still on the port during the first drain cycle.
          if (!r_acc_rd_wrt && (r_rd_pipe == '0)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        RUN_START: begin
          r_state    <= RUN_WAIT;
          r_wait_cnt <= '0;
        end
        RUN_WAIT: begin
          // eol during the first RD_LATENCY cycles belongs to the previous run.
          if ((r_wait_cnt >= WAIT_W'(RD_LATENCY)) && bus.acc_eol) begin
            r_state <= DONE;
            r_done  <= 1'b1;
`ifdef SEQ_RUN_TIMEOUT_EN
          end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            r_acc_eoc <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
`else
          end else if (r_wait_cnt != WAIT_W'(RD_LATENCY)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
`endif
          end
        end
        FINISH: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_RUN_TIMEOUT_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_state == RUN_WAIT) && !((r_wait_cnt >= WAIT_W'(RD_LATENCY)) && bus.acc_eol)
                 && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1))) begin
      r_err <= 1'b1;
    end
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  // Read-return tracking: r_rd_pipe[k] marks a read issued k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pipe <= '0;
      r_credits <= CRD_W'(OFIFO_DEPTH);
    end else begin
      r_rd_pipe <= {r_rd_pipe[RD_LATENCY-2:0], r_acc_valid & r_acc_rd_wrt};
      case ({w_rd_issue, w_pop})
        2'b10:   r_credits <= r_credits - CRD_W'(1);
        2'b01:   r_credits <= r_credits + CRD_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  seq_out_fifo #(
    .DW    (DW),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (bus.acc_data_out),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_comb begin
    w_ctrl = '0;
    w_ctrl[LOG_MEM_NS-1:0] = r_acc_ns;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_ctrl[LOG_MEM_NS + (PE_W + 1) * i +: PE_W + 1] = {r_acc_pe, r_acc_valid};
    end
  end

  assign bus.cmd_ready    = (r_state == IDLE);
  assign bus.in_ready     = (r_state == LOAD);
  assign bus.out_valid    = !w_fifo_empty;
  assign bus.out_data     = w_fifo_head;
  assign bus.acc_start    = r_acc_start;
  assign bus.acc_eoc      = r_acc_eoc;
  assign bus.acc_mem_ctrl = w_ctrl;
  assign bus.acc_rd_wrt   = r_acc_rd_wrt;
  assign bus.acc_data_in  = r_acc_data_in;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;

endmodule

// File: tb/tb_accel_mem_sequencer.sv
// tb/tb_accel_mem_sequencer.sv - self-checking bench for accel_mem_sequencer
module tb_accel_mem_sequencer;
  import accel_seq_pkg::*;

  localparam int DW  = 256;
  localparam int LAT = 5;

  typedef struct {
    int            at;
    logic [DW-1:0] w;
  } pend_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accel_mem_sequencer_if bus ();

  accel_mem_sequencer #(
    .RD_LATENCY  (LAT),
    .OFIFO_DEPTH (8)
`ifdef SEQ_RUN_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int cyc = 0;
  int n_rd_issue = 0, n_ld_beat = 0, n_pop = 0, n_done = 0, n_start = 0, n_eoc = 0;
  int last_ns = -1;
  int first_iss = -1, first_ov = -1;
  int ld_pe[$];
  logic [DW-1:0] ld_data[$];
  logic [DW-1:0] sb_q[$];
  pend_t mq[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  // Accelerator read model plus scoreboard: samples 2 time units after the
  // falling edge, after the stimulus has settled for the coming rising edge.
  initial forever begin
    logic [49:0] exp_ctrl;
    logic [2:0]  lane0;
    logic [DW-1:0] w;
    @(negedge clk);
    #2;
    cyc++;
    if (mq.size() > 0 && mq[0].at == cyc) begin
      bus.acc_data_out = mq[0].w;
      void'(mq.pop_front());
    end else begin
      bus.acc_data_out = {8{32'hDEADBEEF}};
    end
    if (!reset) begin
      lane0 = bus.acc_mem_ctrl[4:2];
      if (lane0[0]) begin
        exp_ctrl = {{16{lane0}}, bus.acc_mem_ctrl[1:0]};
        chk("lane_fields_equal", bus.acc_mem_ctrl, exp_ctrl);
        last_ns = int'(bus.acc_mem_ctrl[1:0]);
        if (bus.acc_rd_wrt) begin
          n_rd_issue++;
          if (first_iss < 0) first_iss = cyc;
          w = rnd_word();
          mq.push_back('{at: cyc + LAT, w: w});
          sb_q.push_back(w);
        end else begin
          n_ld_beat++;
          ld_pe.push_back(int'(lane0[2:1]));
          ld_data.push_back(bus.acc_data_in);
        end
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("out_data", bus.out_data, sb_q.pop_front());
      end
      if (bus.done)      n_done++;
      if (bus.acc_start) n_start++;
      if (bus.acc_eoc)   n_eoc++;
    end
  end

  task automatic send_cmd(input op_e op, input int ns, input int len);
    int k;
    k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_op    = op;
    bus.cmd_ns    = 2'(ns);
    bus.cmd_len   = 16'(len);
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < maxc) begin @(negedge clk); k++; end
    chk(tag, bus.done, 1);
  endtask

  task automatic wait_drained(input int maxc, input string tag);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < maxc) begin @(negedge clk); k++; end
    chk(tag, sb_q.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] ldw [6];
    int exp_pe [6];
    int stall, iss0, pop0, done0, start0, act0, bad, k;
    exp_pe = '{0, 1, 2, 3, 0, 1};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ns = '0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.acc_eol = 1'b0; bus.acc_data_out = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_acc_start", bus.acc_start, 0);
    chk("rst_acc_eoc", bus.acc_eoc, 0);
    chk("rst_acc_rd_wrt", bus.acc_rd_wrt, 0);
    chk("rst_acc_mem_ctrl", bus.acc_mem_ctrl, 0);
    chk("rst_acc_data_in", bus.acc_data_in, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // LOAD ns=1 len=6 with in_valid held high
    for (int i = 0; i < 6; i++) ldw[i] = rnd_word();
    done0 = n_done;
    send_cmd(OP_LOAD, 1, 6);
    stall = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_data  = ldw[i];
      bus.in_valid = 1'b1;
      k = 0;
      while (bus.in_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; stall++; end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("load_stalls", stall, 0);
    chk("load_done_after_last", bus.done, 1);
    chk("load_no_early_done", n_done - done0, 0);
    @(negedge clk);
    chk("load_done_one_cycle", bus.done, 0);
    chk("load_beats", ld_pe.size(), 6);
    for (int i = 0; i < 6 && i < ld_pe.size(); i++) begin
      chk("load_pe_idx", ld_pe[i], exp_pe[i]);
      chk("load_data", ld_data[i], ldw[i]);
    end
    chk("load_ns", last_ns, 1);

    // READ ns=2 len=4, out_ready=1
    first_iss = -1; first_ov = -1;
    pop0 = n_pop; iss0 = n_rd_issue;
    bus.out_ready = 1'b1;
    send_cmd(OP_READ, 2, 4);
    wait_done(80, "read4_done");
    wait_drained(40, "read4_drained");
    chk("read4_issues", n_rd_issue - iss0, 4);
    chk("read4_pops", n_pop - pop0, 4);
    chk("read4_latency", first_ov - first_iss, LAT + 1);
    chk("read4_ns", last_ns, 2);

    // READ len=20 with out_ready=0 -> credit stall at 8
    @(negedge clk);
    bus.out_ready = 1'b0;
    pop0 = n_pop; iss0 = n_rd_issue;
    send_cmd(OP_READ, 3, 20);
    repeat (40) @(negedge clk);
    chk("read20_credit_stall", n_rd_issue - iss0, 8);
    chk("read20_busy", bus.busy, 1);
    chk("read20_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wait_done(300, "read20_done");
    wait_drained(60, "read20_drained");
    chk("read20_issues", n_rd_issue - iss0, 20);
    chk("read20_pops", n_pop - pop0, 20);

    // RUN with eol at cycle 2 (ignored) and cycle 40
    @(negedge clk);
    start0 = n_start; done0 = n_done;
    send_cmd(OP_RUN, 0, 1);
    k = 0;
    while (bus.acc_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("run_start_seen", bus.acc_start, 1);
    bad = 0;
    for (int t = 1; t <= 41; t++) begin
      @(negedge clk);
      bus.acc_eol = (t == 2 || t == 40);
      if (t == 1) chk("run_start_one_cycle", bus.acc_start, 0);
      if (t < 41 && bus.done === 1'b1) bad++;
    end
    chk("run_eol_early_ignored", bad, 0);
    chk("run_done", bus.done, 1);
    chk("run_start_count", n_start - start0, 1);
    @(negedge clk);
    chk("run_done_one_cycle", bus.done, 0);
    chk("run_done_count", n_done - done0, 1);
    chk("err_clear_after_run", bus.err, 0);

    // cmd_len=0 no-op
    act0 = n_rd_issue + n_ld_beat + n_start + n_eoc;
    send_cmd(OP_LOAD, 1, 0);
    chk("len0_done", bus.done, 1);
    chk("len0_idle", bus.busy, 0);
    @(negedge clk);
    chk("len0_done_pulse", bus.done, 0);
    chk("len0_no_activity", n_rd_issue + n_ld_beat + n_start + n_eoc - act0, 0);

    // FINISH
    send_cmd(OP_FINISH, 0, 1);
    chk("fin_eoc", bus.acc_eoc, 1);
    chk("fin_no_done_yet", bus.done, 0);
    @(negedge clk);
    chk("fin_eoc_one_cycle", bus.acc_eoc, 0);
    chk("fin_done", bus.done, 1);
    @(negedge clk);
    chk("fin_idle", bus.cmd_ready, 1);

    // Reset in the middle of a READ
    bus.out_ready = 1'b0;
    iss0 = n_rd_issue;
    send_cmd(OP_READ, 2, 10);
    k = 0;
    while (n_rd_issue - iss0 < 3 && k < 20) begin @(negedge clk); k++; end
    chk("rst_mid_three_issued", n_rd_issue - iss0 >= 3, 1);
    reset = 1'b1;
    @(negedge clk);
    sb_q.delete();
    mq.delete();
    chk("rstm_acc_mem_ctrl", bus.acc_mem_ctrl, 0);
    chk("rstm_acc_rd_wrt", bus.acc_rd_wrt, 0);
    chk("rstm_busy", bus.busy, 0);
    chk("rstm_cmd_ready", bus.cmd_ready, 1);
    chk("rstm_out_valid", bus.out_valid, 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    pop0 = n_pop;
    repeat (12) @(negedge clk);
    chk("rstm_inflight_dropped", n_pop - pop0, 0);
    chk("rstm_fifo_empty", bus.out_valid, 0);

`ifdef SEQ_RUN_TIMEOUT_EN
    done0 = n_done;
    send_cmd(OP_RUN, 0, 1);
    k = 0;
    while (bus.acc_eoc !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    chk("to_eoc", bus.acc_eoc, 1);
    chk("to_err", bus.err, 1);
    chk("to_idle", bus.cmd_ready, 1);
    @(negedge clk);
    chk("to_eoc_one_cycle", bus.acc_eoc, 0);
    chk("to_err_sticky", bus.err, 1);
    chk("to_no_done", n_done - done0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("to_err_reset", bus.err, 0);
`else
    chk("err_tied_low", bus.err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accel_mem_sequencer.md
Name: accel_mem_sequencer

Overview:
Command-driven controller that sequences the accelerator's memory-side port: the start, eoc, mem_ctrl_in, mem_rd_wrt and mem_data_input inputs, and mem_data_output. It executes LOAD, READ, RUN and FINISH commands, walking the PE-lane select field beat by beat. Read returns are captured after the fixed accelerator pipeline latency into a credit-protected output FIFO. It sits between the host/DMA wrapper and the accelerator top.

Parameters:
LOG_MEM_NS, 2, namespace field width (instruction/data/weight/meta)
NUM_LANES, 16, memory lanes per beat
LOG_PE_LANES, 2, PE-select bits per lane; lane groups cycled = 1<<LOG_PE_LANES
DATA_LEN, 16, bits per lane
RD_LATENCY, 5, cycles from read issue to valid mem_data_output (2*MEM_PIPELINE_STAGES+1)
LEN_W, 16, beat-count width
OFIFO_DEPTH, 8, output FIFO entries; power of 2, must be >= RD_LATENCY+1
TIMEOUT_CYCLES, 1048576, RUN watchdog limit (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  0=LOAD 1=READ 2=RUN 3=FINISH
cmd_ns  in  LOG_MEM_NS  target namespace
cmd_len  in  LEN_W  beats; 0 = no-op
in_valid  in  1  load beat offered
in_ready  out  1  load beat accepted
in_data  in  DATA_LEN*NUM_LANES  load beat
out_valid  out  1  read beat available
out_ready  in  1  read beat consumed
out_data  out  DATA_LEN*NUM_LANES  read beat
acc_start  out  1  to accelerator start
acc_eoc  out  1  to accelerator eoc
acc_mem_ctrl  out  LOG_MEM_NS+(LOG_PE_LANES+1)*NUM_LANES  to mem_ctrl_in
acc_rd_wrt  out  1  to mem_rd_wrt; 1=read
acc_data_in  out  DATA_LEN*NUM_LANES  to mem_data_input
acc_data_out  in  DATA_LEN*NUM_LANES  from mem_data_output
acc_eol  in  1  from eol
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on command completion
err  out  1  sticky watchdog flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset: state IDLE. All acc_* outputs, out_valid, done, err and busy are 0. FIFO emptied, credits = OFIFO_DEPTH, pe_idx = 0.
- acc_mem_ctrl layout: [LOG_MEM_NS-1:0] = ns. Lane i field at LOG_MEM_NS+(LOG_PE_LANES+1)*i: bit0 = valid, upper bits = pe_idx. All lanes share one pe_idx; all valids are equal.
- acc_* outputs are registered. When no beat is issued, the valids and acc_rd_wrt are 0, and the ns field holds its last value.
- IDLE: on cmd_valid with len==0, pulse done next cycle and stay in IDLE. Otherwise latch op, ns and len; set beat_cnt=0 and pe_idx=0.
- LOAD: in_ready = 1. On each in_valid&&in_ready, issue one beat: acc_data_in=in_data, valids=1, acc_rd_wrt=0. Then pe_idx++ (wraps mod 1<<LOG_PE_LANES) and beat_cnt++. After beat len-1, go to DONE.
- READ_ISSUE: issue a beat (valids=1, acc_rd_wrt=1) when credits > 0. Each issue decrements credits; each FIFO pop increments them; both in the same cycle leave credits unchanged. After len beats, go to READ_DRAIN.
- Read capture: a RD_LATENCY-deep shift register of the issue strobe. When it emerges, push acc_data_out into the FIFO. Credits guarantee the FIFO never overflows.
- READ_DRAIN: wait until the shift register is empty, then go to DONE. FIFO contents may still be pending; out_valid/out_ready is independent of state.
- RUN: RUN_START drives acc_start=1 for exactly one cycle, then RUN_WAIT. RUN_WAIT must ignore acc_eol for the first RD_LATENCY cycles (stale pipeline). After that, acc_eol=1 leads to DONE.
- FINISH: acc_eoc=1 for one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Reset mid-command aborts immediately. Partially loaded data is not rolled back, and in-flight read data is dropped.
- acc_eol arriving outside RUN_WAIT is ignored.

Optional Feature:
SEQ_RUN_TIMEOUT_EN
- Defined: a cycle counter runs in RUN_WAIT. When it reaches TIMEOUT_CYCLES without acc_eol, set err (sticky until reset), pulse acc_eoc for one cycle, and return to IDLE without asserting done.
- Undefined: no counter; RUN_WAIT waits indefinitely; err is constant 0.

Decomposition:
- Package accel_seq_pkg holds:
  - the op enum (OP_LOAD, OP_READ, OP_RUN, OP_FINISH)
  - the state enum (IDLE, LOAD, READ_ISSUE, READ_DRAIN, RUN_START, RUN_WAIT, FINISH, DONE)
  - a ctrl-field width function
- One sub-module, seq_out_fifo: synchronous FIFO with push, pop, data, and empty/count outputs.

Test Plan:
- LOAD ns=1 len=6, in_valid held high -> 6 consecutive beats; pe_idx sequence 0,1,2,3,0,1; ns field=1; all lane valids high; done 1 cycle after the 6th beat.
- READ ns=2 len=4 with acc_data_out driven from a model of latency 5, out_ready=1 -> out_data returns the 4 model words in order; first out_valid 6 cycles after the first issue.
- READ len=20 with out_ready=0 -> exactly 8 beats issued, then issue stalls; releasing out_ready completes all 20 with no loss or duplication.
- RUN with acc_eol pulsed at cycle 2 and again at cycle 40 -> the cycle-2 pulse is ignored; done 1 cycle after cycle 40; acc_start high exactly 1 cycle.
- cmd_len=0, then FINISH -> immediate done with no acc_* activity; FINISH gives a one-cycle acc_eoc followed by done.
- reset asserted mid-READ after 3 issues -> all outputs 0 next cycle, FIFO empty, cmd_ready=1; with SEQ_RUN_TIMEOUT_EN and TIMEOUT_CYCLES=100, a RUN without eol sets err and pulses acc_eoc.
